// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       memReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegalOp;
    logic       memFault;
    logic [3:0] state;

    modport master (
        input  opcode, zero, memReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegalOp, memFault, state
    );

    modport slave (
        output opcode, zero, memReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegalOp, memFault, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a shared-ALU multicycle MIPS datapath, with a bounded
// wait on the variable-latency unified memory.
module multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:    c.alu_src_b = 2'b11;
            MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
            EXEC_R:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH:    begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
            end
            JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDI_WB:   c.reg_write = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_t              ctrl_q;
    logic               run_q;
    logic               illegal_q, illegal_d;
    logic               fault_q, fault_d;
    logic               mem_wait, timeout, fetch_go;

    always_comb begin
        mem_wait  = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
        timeout   = mem_wait && !bus.memReady && (cnt_q == CNT_W'(WAIT_LIMIT - 1));
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = 1'b0;
        fault_d   = 1'b0;
        // First cycle out of reset only arms the outputs; FETCH proper starts next.
        if (!run_q) begin
            state_d = FETCH;
        end else if (timeout) begin
            state_d = FETCH;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                FETCH, MEM_READ, MEM_WRITE: begin
                    if (bus.memReady) begin
                        case (state_q)
                            FETCH:    state_d = DECODE;
                            MEM_READ: state_d = MEM_WB;
                            default:  state_d = FETCH;
                        endcase
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DECODE: begin
                    case (bus.opcode)
                        OP_R:         state_d = EXEC_R;
                        OP_LW, OP_SW: state_d = MEM_ADDR;
                        OP_BEQ:       state_d = BRANCH;
                        OP_J:         state_d = JUMP;
                        OP_ADDI:      state_d = ADDI_EXEC;
                        default: begin
                            state_d   = FETCH;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
                EXEC_R:    state_d = R_WB;
                ADDI_EXEC: state_d = ADDI_WB;
                default:   state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= decode(state_d);
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    // PC/IR load in FETCH must follow memReady within the same cycle.
    assign fetch_go        = run_q && (state_q == FETCH) && bus.memReady;

    assign bus.PCWrite     = ctrl_q.pc_write | fetch_go;
    assign bus.IRWrite     = fetch_go;
    assign bus.PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.MemToReg    = ctrl_q.mem_to_reg;
    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.PCSource    = ctrl_q.pc_source;
    assign bus.illegalOp   = illegal_q;
    assign bus.memFault    = fault_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: each driven cycle queues the expected state/control word,
// checked on the following falling edge.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if bus ();
    multicycle_control #(.WAIT_LIMIT(15), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    logic [21:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
    //  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegalOp, memFault}
    function automatic logic [21:0] obs_word();
        return {bus.state, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegalOp,
                bus.memFault};
    endfunction

    function automatic logic [21:0] exp_word(input logic [3:0] st, input logic mr,
                                             input logic ill, input logic flt);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rdst = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            4'd9:  begin pcw = 1; psrc = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill, flt};
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            logic [21:0] e;
            e = sb_q.pop_front();
            chk($sformatf("cyc st=%0d", e[21:18]), 32'(obs_word()), 32'(e));
        end
    end

    task automatic step(input logic [5:0] op, input logic z, input logic mr,
                        input logic [3:0] st, input logic ill, input logic flt);
        bus.opcode = op; bus.zero = z; bus.memReady = mr;
        sb_q.push_back(exp_word(st, mr, ill, flt));
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input logic [3:0] s2, input logic [3:0] s3);
        step(op, z, 1'b1, 4'd0, 1'b0, 1'b0);
        step(op, z, 1'b1, 4'd1, 1'b0, 1'b0);
        step(op, z, 1'b1, s2, 1'b0, 1'b0);
        if (s3 != 4'd0) step(op, z, 1'b1, s3, 1'b0, 1'b0);
    endtask

    initial begin
        bus.opcode = '0; bus.zero = 1'b0; bus.memReady = 1'b1;
        #12;
        chk("reset_outs", 32'(obs_word()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("release_idle", 32'(obs_word()), 32'd0);
        @(posedge clk); #1;

        run_instr(6'h00, 1'b0, 4'd6, 4'd7);                    // R-type
        step(6'h23, 0, 1, 4'd0, 0, 0);                          // lw, 3 wait cycles
        step(6'h23, 0, 1, 4'd1, 0, 0);
        step(6'h23, 0, 1, 4'd2, 0, 0);
        for (int i = 0; i < 3; i++) step(6'h23, 0, 0, 4'd3, 0, 0);
        step(6'h23, 0, 1, 4'd3, 0, 0);
        step(6'h23, 0, 1, 4'd4, 0, 0);
        run_instr(6'h04, 1'b1, 4'd8, 4'd0);                    // beq taken
        run_instr(6'h04, 1'b0, 4'd8, 4'd0);                    // beq not taken
        step(6'h3F, 0, 1, 4'd0, 0, 0);                          // illegal opcode
        step(6'h3F, 0, 1, 4'd1, 0, 0);
        step(6'h02, 0, 1, 4'd0, 1, 0);                          // j, illegalOp seen in this FETCH
        step(6'h02, 0, 1, 4'd1, 0, 0);
        step(6'h02, 0, 1, 4'd9, 0, 0);
        run_instr(6'h08, 1'b0, 4'd10, 4'd11);                  // addi
        step(6'h2B, 0, 1, 4'd0, 0, 0);                          // sw, memory hangs
        step(6'h2B, 0, 1, 4'd1, 0, 0);
        step(6'h2B, 0, 1, 4'd2, 0, 0);
        for (int i = 0; i < 15; i++) step(6'h2B, 0, 0, 4'd5, 0, 0);
        step(6'h00, 0, 0, 4'd0, 0, 1);                          // fault cycle
        step(6'h00, 0, 1, 4'd0, 0, 0);
        step(6'h00, 0, 1, 4'd1, 0, 0);
        step(6'h00, 0, 1, 4'd6, 0, 0);
        step(6'h00, 0, 1, 4'd7, 0, 0);
        step(6'h2B, 0, 1, 4'd0, 0, 0);                          // sw ready on the limit cycle
        step(6'h2B, 0, 1, 4'd1, 0, 0);
        step(6'h2B, 0, 1, 4'd2, 0, 0);
        for (int i = 0; i < 14; i++) step(6'h2B, 0, 0, 4'd5, 0, 0);
        step(6'h2B, 0, 1, 4'd5, 0, 0);
        for (int i = 0; i < 15; i++) step(6'h00, 0, 0, 4'd0, 0, 0);  // FETCH timeout
        step(6'h00, 0, 1, 4'd0, 0, 1);
        step(6'h00, 0, 1, 4'd1, 0, 0);
        step(6'h00, 0, 1, 4'd6, 0, 0);
        step(6'h00, 0, 1, 4'd7, 0, 0);
        step(6'h23, 0, 1, 4'd0, 0, 0);                          // lw, reset in MEM_WB
        step(6'h23, 0, 1, 4'd1, 0, 0);
        step(6'h23, 0, 1, 4'd2, 0, 0);
        step(6'h23, 0, 1, 4'd3, 0, 0);
        chk("memwb_regwrite", 32'(bus.RegWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("async_abort", 32'(obs_word()), 32'd0);
        @(posedge clk); #1;
        chk("held_reset", 32'(obs_word()), 32'd0);
        rst_n = 1'b1;
        #1 chk("rerelease_idle", 32'(obs_word()), 32'd0);
        @(posedge clk); #1;
        run_instr(6'h00, 1'b0, 4'd6, 4'd7);
        @(posedge clk); #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
